// File: rtl/seq_mul_16_pkg.sv
// Shared execute-stage definitions for the sequential multiplier: FSM encoding,
// datapath width and the iteration-count terminal value.
package seq_mul_16_pkg;

    localparam int unsigned DataWidth = 16;

    // Last value of the iteration counter; the RUN cycle with this count is the final one.
    localparam logic [3:0] CountLast = 4'd15;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StRun  = 2'd1,
        StDone = 2'd2
    } state_e;

endpackage

// File: rtl/seq_mul_16.sv
// Sequential unsigned shift-add multiplier. One iteration per RUN cycle, 16 iterations,
// then a single DONE cycle. product_lo feeds the writeback mux B input.
module seq_mul_16
    import seq_mul_16_pkg::*;
#(
    parameter int unsigned WIDTH = DataWidth
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] product_lo,
    output logic [WIDTH-1:0] product_hi
);

    state_e           r_state;
    state_e           w_state_next;
    logic [WIDTH:0]   r_acc;    // carry bit plus the high half of the product
    logic [WIDTH-1:0] r_mq;     // low half of the product; starts as the multiplier
    logic [WIDTH-1:0] r_mcand;
    logic [3:0]       r_count;
    logic [WIDTH:0]   w_sum;

    // Conditional add of the multiplicand; r_acc[WIDTH] is always 0 here, so the
    // 17-bit add cannot overflow.
    assign w_sum = r_mq[0] ? (r_acc + {1'b0, r_mcand}) : r_acc;

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= StIdle;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state logic; start is only honoured in IDLE, unused encoding returns to IDLE.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            StIdle:  if (start) w_state_next = StRun;
            StRun:   if (r_count == CountLast) w_state_next = StDone;
            StDone:  w_state_next = StIdle;
            default: w_state_next = StIdle;
        endcase
    end

    // Operand capture and one shift-add iteration per RUN cycle; registers hold otherwise.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_acc   <= '0;
            r_mq    <= '0;
            r_mcand <= '0;
            r_count <= '0;
        end else begin
            case (r_state)
                StIdle: begin
                    if (start) begin
                        r_mcand <= a;
                        r_mq    <= b;
                        r_acc   <= '0;
                        r_count <= '0;
                    end
                end
                StRun: begin
                    // Right shift of {sum, mq} by one bit.
                    r_acc   <= {1'b0, w_sum[WIDTH:1]};
                    r_mq    <= {w_sum[0], r_mq[WIDTH-1:1]};
                    r_count <= r_count + 4'd1;
                end
                default: begin
                end
            endcase
        end
    end

    // Outputs decode straight from registers.
    assign busy       = (r_state == StRun);
    assign done       = (r_state == StDone);
    assign product_hi = r_acc[WIDTH-1:0];
    assign product_lo = r_mq;

endmodule

// File: tb/tb_seq_mul_16.sv
// Self-checking bench for seq_mul_16: directed cases plus a random regression against
// a plain a*b reference, with latency and handshake-shape checks.
module tb_seq_mul_16;

    logic        clk;
    logic        rst;
    logic        start;
    logic [15:0] a;
    logic [15:0] b;
    logic        busy;
    logic        done;
    logic [15:0] product_lo;
    logic [15:0] product_hi;

    int n_checks = 0;
    int n_pass   = 0;
    bit mon_en   = 1'b0;
    logic prev_done = 1'b0;

    seq_mul_16 #(.WIDTH(16)) u_dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .a          (a),
        .b          (b),
        .busy       (busy),
        .done       (done),
        .product_lo (product_lo),
        .product_hi (product_hi)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Handshake shape: busy/done exclusive, done never two cycles in a row.
    always @(negedge clk) begin
        if (mon_en) begin
            check("busy_done_excl", 32'(busy && done), 32'd0);
            check("done_one_cycle", 32'(done && prev_done), 32'd0);
        end
        prev_done = done;
    end

    // Called at a negedge in IDLE. Drives start this cycle, then scribbles on a/b while
    // running. With noisy set, start is re-pulsed in RUN cycles 5 and 16 and in DONE.
    // Returns at a negedge in the IDLE cycle after DONE.
    task automatic run_op(input logic [15:0] op_a, input logic [15:0] op_b, input bit noisy);
        int          k;
        int          busy_cycles;
        logic [31:0] exp;
        exp         = 32'(op_a) * 32'(op_b);
        a           = op_a;
        b           = op_b;
        start       = 1'b1;
        k           = 0;
        busy_cycles = 0;
        do begin
            @(negedge clk);
            k++;
            if (busy) busy_cycles++;
            a = 16'($urandom);
            b = 16'($urandom);
            start = noisy && (k == 5 || k == 16 || done);
        end while (!done && k < 40);
        check("latency", 32'(k), 32'd17);
        check("busy_cycles", 32'(busy_cycles), 32'd16);
        check("product_lo", 32'(product_lo), 32'(exp[15:0]));
        check("product_hi", 32'(product_hi), 32'(exp[31:16]));
        @(negedge clk);
        start = 1'b0;
        check("idle_busy", 32'(busy), 32'd0);
        check("idle_done", 32'(done), 32'd0);
        check("held_lo", 32'(product_lo), 32'(exp[15:0]));
        check("held_hi", 32'(product_hi), 32'(exp[31:16]));
    endtask

    initial begin
        rst   = 1'b1;
        start = 1'b0;
        a     = 16'h0;
        b     = 16'h0;
        repeat (3) @(negedge clk);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_lo", 32'(product_lo), 32'd0);
        check("rst_hi", 32'(product_hi), 32'd0);
        rst    = 1'b0;
        mon_en = 1'b1;

        // Directed cases; each starts in the first IDLE cycle after the previous result.
        run_op(16'd3, 16'd5, 1'b0);
        run_op(16'hFFFF, 16'hFFFF, 1'b0);
        run_op(16'h1234, 16'h0000, 1'b0);
        run_op(16'h0000, 16'hABCD, 1'b0);
        run_op(16'h00C8, 16'h0102, 1'b1);
        check("ignored_start_ref", 32'({product_hi, product_lo}), 32'h0000_C990);

        // Reset in RUN cycle 8 aborts with outputs cleared and no done pulse.
        a     = 16'hBEEF;
        b     = 16'h1357;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (7) @(negedge clk);
        check("pre_rst_busy", 32'(busy), 32'd1);
        #2 rst = 1'b1;
        #1;
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_done", 32'(done), 32'd0);
        check("abort_lo", 32'(product_lo), 32'd0);
        check("abort_hi", 32'(product_hi), 32'd0);
        repeat (2) @(negedge clk);
        check("abort_no_done", 32'(done), 32'd0);
        rst = 1'b0;
        run_op(16'd7, 16'd9, 1'b0);
        check("post_rst_ref", 32'(product_lo), 32'h003F);

        // Random regression.
        for (int i = 0; i < 1000; i++) begin
            run_op(16'($urandom), 16'($urandom), 1'b0);
        end

        mon_en = 1'b0;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
